// File: rtl/button_reader.sv
// Debounced reader for one raw, asynchronous, bouncy input pin.
// Produces a clean level, single-cycle rise/fall pulses and a wrapping press counter.
module button_reader #(
    parameter int DEBOUNCE_CYCLES = 12000,
    parameter int CNT_W           = 16,
    parameter int PRESS_W         = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in,
    input  logic               clr,
    output logic               out,
    output logic               rise,
    output logic               fall,
    output logic               busy,
    output logic [PRESS_W-1:0] presses
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        SETTLE_HIGH = 2'd1,
        STABLE_HIGH = 2'd2,
        SETTLE_LOW  = 2'd3
    } state_t;

    // Final settle count: acceptance happens when the counter already holds this value.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]         sync_reg;
    logic               s;
    state_t             state_reg;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [CNT_W-1:0]   cnt_next;
    logic               rise_reg;
    logic               rise_next;
    logic               fall_reg;
    logic               fall_next;
    logic [PRESS_W-1:0] presses_reg;
    logic [PRESS_W-1:0] presses_next;

    // Two-flop synchronizer; the raw pin feeds nothing else.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], in};
        end
    end

    assign s = sync_reg[1];

    // State register, including the registered pulses and press counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= STABLE_LOW;
            cnt_reg     <= '0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
            presses_reg <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rise_reg    <= rise_next;
            fall_reg    <= fall_next;
            presses_reg <= presses_next;
        end
    end

    // Next-state logic: a settle is aborted by a single sample back at the old level.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        case (state_reg)
            STABLE_LOW: begin
                if (s) begin
                    state_next = SETTLE_HIGH;
                    cnt_next   = CNT_ONE;
                end
            end
            SETTLE_HIGH: begin
                if (!s) begin
                    state_next = STABLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = STABLE_HIGH;
                    cnt_next   = '0;
                    rise_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_next = SETTLE_LOW;
                    cnt_next   = CNT_ONE;
                end
            end
            SETTLE_LOW: begin
                if (s) begin
                    state_next = STABLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next = STABLE_LOW;
                    cnt_next   = '0;
                    fall_next  = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = STABLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    // The counter steps on the same edge that raises rise; clear takes priority.
    always_comb begin
        presses_next = presses_reg;
        if (clr) begin
            presses_next = '0;
        end else if (rise_next) begin
            presses_next = presses_reg + PRESS_W'(1);
        end
    end

    // Output decode from the registered state.
    always_comb begin
        out     = (state_reg == STABLE_HIGH) || (state_reg == SETTLE_LOW);
        busy    = (state_reg == SETTLE_HIGH) || (state_reg == SETTLE_LOW);
        rise    = rise_reg;
        fall    = fall_reg;
        presses = presses_reg;
    end

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader with DEBOUNCE_CYCLES=4, PRESS_W=8.
// Table-driven cycle vectors plus hand-written multi-cycle sequences.
module tb_button_reader;

    logic       clk;
    logic       rstn;
    logic       in;
    logic       clr;
    logic       out;
    logic       rise;
    logic       fall;
    logic       busy;
    logic [7:0] presses;

    int checks;
    int errors;

    button_reader #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(16),
        .PRESS_W(8)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in(in),
        .clr(clr),
        .out(out),
        .rise(rise),
        .fall(fall),
        .busy(busy),
        .presses(presses)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic in;
        logic clr;
        logic out;
        logic rise;
        logic fall;
        logic busy;
        int   presses;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic i, logic c, logic o, logic r, logic f, logic b, int p);
        vec_t v;
        v.in = i; v.clr = c; v.out = o; v.rise = r; v.fall = f; v.busy = b; v.presses = p;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic o, input logic r, input logic f,
                             input logic b, input int p);
        check({tag, ".out"}, int'(out), int'(o));
        check({tag, ".rise"}, int'(rise), int'(r));
        check({tag, ".fall"}, int'(fall), int'(f));
        check({tag, ".busy"}, int'(busy), int'(b));
        check({tag, ".presses"}, int'(presses), p);
    endtask

    task automatic press();
        in = 1'b1;
        repeat (8) step();
        in = 1'b0;
        repeat (8) step();
    endtask

    initial begin
        clk    = 1'b0;
        rstn   = 1'b0;
        in     = 1'b0;
        clr    = 1'b0;
        checks = 0;
        errors = 0;

        // Bounce on a press, single-cycle glitch on a held high, clean release, then clear.
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 1, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[6]  = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[7]  = mk(1, 0, 0, 0, 0, 1, 0);
        vecs[8]  = mk(1, 0, 1, 1, 0, 0, 1);
        vecs[9]  = mk(1, 0, 1, 0, 0, 0, 1);
        vecs[10] = mk(0, 0, 1, 0, 0, 0, 1);
        vecs[11] = mk(1, 0, 1, 0, 0, 0, 1);
        vecs[12] = mk(1, 0, 1, 0, 0, 1, 1);
        vecs[13] = mk(1, 0, 1, 0, 0, 0, 1);
        vecs[14] = mk(1, 0, 1, 0, 0, 0, 1);
        vecs[15] = mk(0, 0, 1, 0, 0, 0, 1);
        vecs[16] = mk(0, 0, 1, 0, 0, 0, 1);
        vecs[17] = mk(0, 0, 1, 0, 0, 1, 1);
        vecs[18] = mk(0, 0, 1, 0, 0, 1, 1);
        vecs[19] = mk(0, 0, 1, 0, 0, 1, 1);
        vecs[20] = mk(0, 0, 0, 0, 1, 0, 1);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 1);
        vecs[22] = mk(0, 1, 0, 0, 0, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0);

        // Reset held while the pin toggles: everything stays at zero.
        for (int k = 0; k < 6; k++) begin
            in = k[0];
            step();
            check_all($sformatf("rst%0d", k), 0, 0, 0, 0, 0);
        end
        in   = 1'b0;
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_all($sformatf("idle%0d", k), 0, 0, 0, 0, 0);
        end

        for (int k = 0; k < NVEC; k++) begin
            in  = vecs[k].in;
            clr = vecs[k].clr;
            step();
            check_all($sformatf("vec%0d", k), vecs[k].out, vecs[k].rise, vecs[k].fall,
                      vecs[k].busy, vecs[k].presses);
        end
        clr = 1'b0;

        // Counter wrap after 256 presses.
        for (int k = 1; k <= 255; k++) begin
            press();
            check($sformatf("cnt%0d", k), int'(presses), k);
        end
        check("cnt255.out", int'(out), 0);
        press();
        check("wrap", int'(presses), 0);

        // Clear on the same edge as a rise wins.
        press();
        check("pre_clr", int'(presses), 1);
        in = 1'b1;
        repeat (5) step();
        check("clr_rise.busy", int'(busy), 1);
        clr = 1'b1;
        step();
        check("clr_rise.rise", int'(rise), 1);
        check("clr_rise.presses", int'(presses), 0);
        clr = 1'b0;
        step();
        check("clr_after.rise", int'(rise), 0);
        check("clr_after.presses", int'(presses), 0);
        repeat (6) step();
        in = 1'b0;
        repeat (8) step();
        press();
        check("post_clr_press", int'(presses), 1);

        // Asynchronous reset in the middle of a settle.
        in = 1'b1;
        repeat (4) step();
        check("mid.busy", int'(busy), 1);
        check("mid.out", int'(out), 0);
        rstn = 1'b0;
        in   = 1'b0;
        #1;
        check_all("arst", 0, 0, 0, 0, 0);
        repeat (2) step();
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("arst_rel%0d.rise", k), int'(rise), 0);
            check($sformatf("arst_rel%0d.busy", k), int'(busy), 0);
        end
        check("arst_rel.presses", int'(presses), 0);

        // Power-up with the pin already high.
        rstn = 1'b0;
        in   = 1'b1;
        step();
        check_all("pwr_rst", 0, 0, 0, 0, 0);
        rstn = 1'b1;
        repeat (5) step();
        check("pwr5.busy", int'(busy), 1);
        check("pwr5.out", int'(out), 0);
        step();
        check_all("pwr6", 1, 1, 0, 0, 1);
        step();
        check_all("pwr7", 1, 0, 0, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
